// File: rtl/lsu_handshake.sv
// Load/store unit: request/acknowledge handshake to the external data bus,
// byte-lane steering for stores, sign/zero extension for loads, and error
// responses for misaligned accesses and bus timeouts.
module lsu_handshake #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_func,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              stall,
    output logic [ADDR_W-1:0] DAD,
    output logic              MREQ,
    output logic              WRITE,
    output logic [1:0]        SIZE,
    input  logic              ACKD_n,
    output logic [XLEN-1:0]   ddt_o,
    output logic              ddt_oe,
    input  logic [XLEN-1:0]   ddt_i
);

    localparam int unsigned LANES  = XLEN / 8;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_write;
    logic [2:0]          r_func;
    logic [LANE_W-1:0]   r_lane;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_rdata_raw;

    logic                w_misal;
    logic [1:0]          w_size;
    logic [XLEN-1:0]     w_store;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [XLEN-1:0]     w_load;

    // Alignment check and bus size encoding for the incoming request
    always_comb begin
        w_misal = 1'b0;
        w_size  = 2'b00;
        case (req_func)
            3'b000, 3'b100: begin
                w_misal = 1'b0;
                w_size  = 2'b10;
            end
            3'b001, 3'b101: begin
                w_misal = req_addr[0];
                w_size  = 2'b01;
            end
            3'b010: begin
                w_misal = (req_addr[1:0] != 2'b00);
                w_size  = 2'b00;
            end
            default: begin
                w_misal = 1'b1;
                w_size  = 2'b00;
            end
        endcase
    end

    // Store lane steering: replicate narrow data across all lanes
    always_comb begin
        w_store = req_wdata;
        case (req_func[1:0])
            2'b00:   w_store = {LANES{req_wdata[7:0]}};
            2'b01:   w_store = {(LANES / 2){req_wdata[15:0]}};
            default: w_store = req_wdata;
        endcase
    end

    // Load extraction and extension from the captured bus word
    always_comb begin
        w_byte = r_rdata_raw[{r_lane, 3'b000} +: 8];
        w_half = r_rdata_raw[{r_lane[LANE_W-1:1], 4'b0000} +: 16];
        case (r_func)
            3'b000:  w_load = {{(XLEN - 8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(XLEN - 16){w_half[15]}}, w_half};
            3'b100:  w_load = {{(XLEN - 8){1'b0}}, w_byte};
            3'b101:  w_load = {{(XLEN - 16){1'b0}}, w_half};
            default: w_load = r_rdata_raw;
        endcase
    end

    // Requests are taken only in IDLE once the previous response has retired
    assign req_ready = (r_state == ST_IDLE) && !rsp_valid;

    // Core holds the PC until the response pulse
    assign stall = req_valid && !rsp_valid;

    // Access FSM with registered bus and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_func      <= 3'b000;
            r_lane      <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_rdata_raw <= '0;
            DAD         <= '0;
            MREQ        <= 1'b0;
            WRITE       <= 1'b0;
            SIZE        <= 2'b00;
            ddt_o       <= '0;
            ddt_oe      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_write <= req_write;
                        r_func  <= req_func;
                        r_lane  <= req_addr[LANE_W-1:0];
                        if (w_misal) begin
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_cnt   <= '0;
                            MREQ    <= 1'b1;
                            WRITE   <= req_write;
                            SIZE    <= w_size;
                            DAD     <= req_addr;
                            ddt_o   <= w_store;
                            ddt_oe  <= req_write;
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!ACKD_n) begin
                        r_rdata_raw <= ddt_i;
                        MREQ        <= 1'b0;
                        WRITE       <= 1'b0;
                        ddt_oe      <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                        r_err   <= 1'b1;
                        MREQ    <= 1'b0;
                        WRITE   <= 1'b0;
                        ddt_oe  <= 1'b0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= r_err;
                    rsp_rdata <= (r_err || r_write) ? '0 : w_load;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench for lsu_handshake: stimulus pushes expected responses into a
// scoreboard queue; a monitor pops and compares on every rsp_valid pulse.
module tb_lsu_handshake;

    localparam int unsigned TO = 15;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n;
    logic [31:0] ddt_o;
    logic        ddt_oe;
    logic [31:0] ddt_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc;
    int   n_chk;
    int   n_err;

    lsu_handshake #(
        .XLEN    (32),
        .ADDR_W  (32),
        .TIMEOUT (TO),
        .CNT_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_func  (req_func),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .stall     (stall),
        .DAD       (DAD),
        .MREQ      (MREQ),
        .WRITE     (WRITE),
        .SIZE      (SIZE),
        .ACKD_n    (ACKD_n),
        .ddt_o     (ddt_o),
        .ddt_oe    (ddt_oe),
        .ddt_i     (ddt_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response pulse must match the head of the queue
    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected no response", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("rsp", "rdata", rsp_rdata, mon_e.rdata);
                chk("rsp", "err", 32'(rsp_err), 32'(mon_e.err));
                chk("rsp", "cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("rsp", "stall", 32'(stall), 32'd0);
            end
        end
    end

    // mode: 0 = acked after 'waits' wait states, 1 = misaligned, 2 = no ack (timeout)
    task automatic access(input string tag, input logic wr, input logic [2:0] fn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdat, input int waits, input int mode,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_size,
                          input logic [31:0] exp_ddto);
        exp_t e;
        int   k;
        int   mreq_cnt;
        int   exp_mreq;
        bit   done;
        @(negedge clk);
        chk(tag, "req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_func  = fn;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        e.rdata = exp_rdata;
        e.err   = (mode != 0);
        e.cyc   = cyc + ((mode == 1) ? 1 : (mode == 2) ? int'(TO) + 1 : waits + 2);
        q.push_back(e);
        k        = 0;
        mreq_cnt = 0;
        done     = 1'b0;
        while (!done && k < 64) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                if (MREQ === 1'b1) mreq_cnt++;
                if (k == 0) begin
                    chk(tag, "stall", 32'(stall), 32'd1);
                    chk(tag, "MREQ", 32'(MREQ), (mode == 1) ? 32'd0 : 32'd1);
                    if (mode != 1) begin
                        chk(tag, "WRITE", 32'(WRITE), 32'(wr));
                        chk(tag, "SIZE", 32'(SIZE), 32'(exp_size));
                        chk(tag, "DAD", DAD, addr);
                        chk(tag, "ddt_oe", 32'(ddt_oe), 32'(wr));
                        if (wr) chk(tag, "ddt_o", ddt_o, exp_ddto);
                    end
                end
                if (mode == 0 && k == waits + 1) begin
                    chk(tag, "MREQ_drop", 32'(MREQ), 32'd0);
                    chk(tag, "ddt_oe_drop", 32'(ddt_oe), 32'd0);
                end
                if (mode == 0 && k == waits) begin
                    ACKD_n = 1'b0;
                    ddt_i  = rdat;
                end else begin
                    ACKD_n = 1'b1;
                    ddt_i  = 32'h0;
                end
                k++;
            end
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL %s.rsp_wait: got no rsp_valid within 64 cycles expected a response", tag);
        end
        exp_mreq = (mode == 0) ? waits + 1 : (mode == 2) ? int'(TO) : 0;
        chk(tag, "mreq_cycles", 32'(mreq_cnt), 32'(exp_mreq));
        req_valid = 1'b0;
        ACKD_n    = 1'b1;
    endtask

    initial begin
        int guard;
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_func  = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        ACKD_n    = 1'b1;
        ddt_i     = 32'h0;
        #1;
        chk("reset", "MREQ", 32'(MREQ), 32'd0);
        chk("reset", "WRITE", 32'(WRITE), 32'd0);
        chk("reset", "SIZE", 32'(SIZE), 32'd0);
        chk("reset", "DAD", DAD, 32'd0);
        chk("reset", "ddt_o", ddt_o, 32'd0);
        chk("reset", "ddt_oe", 32'(ddt_oe), 32'd0);
        chk("reset", "rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset", "rsp_rdata", rsp_rdata, 32'd0);
        chk("reset", "rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        access("lw",   1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 2'b00, 32'h0);
        access("lb",   1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_0000, 3, 0, 32'hFFFF_FF80, 2'b10, 32'h0);
        access("lbu",  1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_0000, 3, 0, 32'h0000_0080, 2'b10, 32'h0);
        access("sh",   1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 0, 32'h0, 2'b01, 32'hABCD_ABCD);
        access("lw_misal", 1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0, 1, 32'h0, 2'b00, 32'h0);
        access("lh_to", 1'b0, 3'b001, 32'h0000_5000, 32'h0, 32'h0, 0, 2, 32'h0, 2'b01, 32'h0);
        access("lhu",  1'b0, 3'b101, 32'h0000_6002, 32'h0, 32'h8001_1234, 0, 0, 32'h0000_8001, 2'b01, 32'h0);
        access("lh",   1'b0, 3'b001, 32'h0000_6002, 32'h0, 32'h8001_1234, 2, 0, 32'hFFFF_8001, 2'b01, 32'h0);
        access("lh_lo", 1'b0, 3'b001, 32'h0000_6000, 32'h0, 32'h8001_7234, 0, 0, 32'h0000_7234, 2'b01, 32'h0);
        access("sb",   1'b1, 3'b000, 32'h0000_7001, 32'h0000_00A5, 32'h0, 0, 0, 32'h0, 2'b10, 32'hA5A5_A5A5);
        access("sw",   1'b1, 3'b010, 32'h0000_7004, 32'hCAFE_F00D, 32'h0, 2, 0, 32'h0, 2'b00, 32'hCAFE_F00D);
        access("bad_func", 1'b0, 3'b011, 32'h0000_7000, 32'h0, 32'h0, 0, 1, 32'h0, 2'b00, 32'h0);

        // Acknowledge while idle must produce no activity
        @(negedge clk);
        ACKD_n = 1'b0;
        ddt_i  = 32'h5555_5555;
        repeat (2) @(negedge clk);
        chk("idle_ack", "MREQ", 32'(MREQ), 32'd0);
        ACKD_n = 1'b1;
        ddt_i  = 32'h0;
        access("lb_after", 1'b0, 3'b000, 32'h0000_8001, 32'h0, 32'h0000_7F00, 0, 0, 32'h0000_007F, 2'b10, 32'h0);

        // Reset in the middle of an access aborts it silently
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_func  = 3'b010;
        req_addr  = 32'h0000_9000;
        req_wdata = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid", "MREQ_before", 32'(MREQ), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid", "MREQ", 32'(MREQ), 32'd0);
        chk("rst_mid", "DAD", DAD, 32'd0);
        chk("rst_mid", "ddt_oe", 32'(ddt_oe), 32'd0);
        chk("rst_mid", "rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", "req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid", "MREQ_after", 32'(MREQ), 32'd0);
        repeat (3) @(negedge clk);
        access("lw_post", 1'b0, 3'b010, 32'h0000_A000, 32'h0, 32'h0123_4567, 1, 0, 32'h0123_4567, 2'b00, 32'h0);

        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("end", "queue_empty", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_handshake.md
Name: lsu_handshake

Overview:
- Parametrised load/store unit that sits between the core's execute stage and the external data-memory bus (DAD/MREQ/WRITE/SIZE/DDT/ACKD_n).
- Replaces the single-cycle toggle-based load stall with a real request/acknowledge handshake: variable wait states, byte-lane steering, load sign/zero extension, misalignment and bus-timeout error reporting.
- Drives a stall to the PC logic until each access completes.

Parameters:
XLEN, 32, data path width; only 32 supported in this generation. Lane logic is written over XLEN/8 lanes.
ADDR_W, 32, width of req_addr and DAD.
TIMEOUT, 15, number of ACCESS cycles without ACKD_n before an error response; 0 disables the timeout.
CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  1  execute stage presents a load/store
req_ready  output  1  unit is able to accept a request (IDLE only)
req_write  input  1  1 = store, 0 = load
req_func  input  3  RV32 funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
req_addr  input  ADDR_W  byte address (ALU result)
req_wdata  input  XLEN  store data (rs2), right-aligned
rsp_valid  output  1  one-cycle pulse: access finished
rsp_rdata  output  XLEN  extended load data; 0 for stores and errors
rsp_err  output  1  valid with rsp_valid: misaligned or timeout
stall  output  1  hold PC and register-file write
DAD  output  ADDR_W  data memory address
MREQ  output  1  bus request, active high
WRITE  output  1  store when MREQ=1
SIZE  output  2  00 word, 01 half, 10 byte
ACKD_n  input  1  memory acknowledge, active low
ddt_o  output  XLEN  store data to DDT pad
ddt_oe  output  1  DDT output enable (MREQ and WRITE)
ddt_i  input  XLEN  load data from DDT pad

Behaviour:
- Reset (rst=0, async): state=IDLE; MREQ=0, WRITE=0, SIZE=00, DAD=0, ddt_o=0, ddt_oe=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0. Reset asserted mid-access aborts it with no response.
- All bus outputs are registered.
- FSM IDLE -> ACCESS -> RESP -> IDLE. A misaligned request goes IDLE -> RESP directly.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, func, addr and wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or func 011/11x) -> RESP with err=1; MREQ is never raised.
  - Otherwise -> ACCESS, with MREQ=1, WRITE=req_write, SIZE from func[1:0] and DAD=req_addr registered on the same edge.
- ACCESS:
  - Bus outputs held stable.
  - ACKD_n sampled on each rising edge. When low: capture ddt_i, go to RESP and drop MREQ/WRITE/ddt_oe on that edge.
  - If TIMEOUT>0 and the counter reaches TIMEOUT without an ack -> RESP with err=1 and MREQ dropped.
  - Counter clears on entry to ACCESS.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. A new request may be accepted on the next cycle.
- Latency: request accepted at edge 0, zero-wait ack sampled at edge 1, rsp_valid high during the cycle after edge 2. Each wait state adds 1 cycle.
- stall = req_valid and not rsp_valid (combinational). The core holds req_* stable while stall=1.
- Store lanes, little-endian: byte data replicated to all 4 lanes; half data replicated to both halves; word data passed through.
- Load extraction:
  - byte = ddt_i[8*addr[1:0]+:8]; half = ddt_i[16*addr[1]+:16].
  - Sign-extend for 000/001, zero-extend for 100/101; word passed through.
- ACKD_n low while in IDLE or RESP is ignored.

Test Plan:
- lw addr 0x1004, ACKD_n low 1 cycle after MREQ, ddt_i=0xDEADBEEF -> SIZE=00, DAD=0x1004; rsp_valid 2 cycles after accept; rsp_rdata=0xDEADBEEF, err=0.
- lb addr 0x2003, ddt_i=0x80FF_0000, 3 wait states -> rsp_rdata=0xFFFFFF80 exactly 3 cycles later than the zero-wait case. Repeat as lbu -> 0x00000080.
- sh addr 0x3002, wdata=0x1234ABCD -> WRITE=1, SIZE=01, ddt_o=0xABCDABCD, ddt_oe=1 until ack; rsp_rdata=0.
- lw addr 0x4002 -> MREQ never asserted; rsp_valid with err=1 one cycle after accept.
- lh addr 0x5000, ACKD_n held high, TIMEOUT=15 -> MREQ high for 15 cycles, then rsp_err=1; next request accepted normally.
- rst pulled low while in ACCESS -> MREQ=0 immediately (async); no rsp_valid; after release state is IDLE and req_ready=1.
